regfile_mp: RTL and testbench

//  Parametrised multi-port integer register file; next generation of the core's single-write, dual-read regfile.
//  N read ports, M write ports (superscalar / multi-writeback), same-cycle write-to-read bypass, x0 hardwired zero.

---
 rtl/regfile_mp.sv | 107 ++++++++++
 tb/tb_regfile_mp.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: NRD-read / NWR-write integer register file, x0 = 0, write-to-read bypass, post-reset clear FSM.
// Reads are combinational (0 cycles), writes land on the next edge; no backpressure, o_ready low during INIT stalls the pipeline.
package rapid_pkg;
   localparam logic [31:0] RESET_STACK_POINTER = 32'h8000_F000;
endpackage

module regfile_mp #(
   parameter int             XLEN     = 32,
   parameter int             NREGS    = 32,
   parameter int             NRD      = 2,
   parameter int             NWR      = 2,
   parameter int             SP_IDX   = 2,
   parameter logic [XLEN-1:0] SP_RESET = XLEN'(rapid_pkg::RESET_STACK_POINTER),
   localparam int            AW       = $clog2(NREGS)
) (
   input  logic                i_clk,
   input  logic                i_reset_n,
   input  logic [NRD*AW-1:0]   i_rd_addr,
   output logic [NRD*XLEN-1:0] o_rd_data,
   input  logic [NWR-1:0]      i_wr_en,
   input  logic [NWR*AW-1:0]   i_wr_addr,
   input  logic [NWR*XLEN-1:0] i_wr_data,
   output logic                o_ready,
   output logic [AW-1:0]       o_init_idx
);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t          state, state_nxt;
   logic [AW-1:0]   init_idx, init_idx_nxt;
   logic [XLEN-1:0] regs [NREGS];

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state    <= S_INIT;
         init_idx <= AW'(1);
      end else begin
         state    <= state_nxt;
         init_idx <= init_idx_nxt;
      end
   end

   // init_idx parks at 0 once the sweep finishes, so it never wraps onto x0
   always_comb begin
      state_nxt    = state;
      init_idx_nxt = init_idx;
      case (state)
         S_INIT: begin
            if (init_idx == AW'(NREGS - 1)) begin
               state_nxt    = S_RUN;
               init_idx_nxt = '0;
            end else begin
               init_idx_nxt = init_idx + AW'(1);
            end
         end
         S_RUN:   state_nxt = S_RUN;
         default: state_nxt = S_INIT;
      endcase
   end

   assign o_ready    = (state == S_RUN);
   assign o_init_idx = init_idx;

   // Later loop iterations override earlier ones: highest-numbered port wins a conflict
   always_ff @(posedge i_clk) begin
      if (i_reset_n) begin
         if (state == S_INIT) begin
            regs[init_idx] <= (init_idx == AW'(SP_IDX)) ? SP_RESET : '0;
         end else begin
            for (int j = 0; j < NWR; j++) begin
               if (i_wr_en[j] && (i_wr_addr[j*AW +: AW] != '0)) begin
                  regs[i_wr_addr[j*AW +: AW]] <= i_wr_data[j*XLEN +: XLEN];
               end
            end
         end
      end
   end

   always_comb begin
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rv;
      o_rd_data = '0;
      ra        = '0;
      rv        = '0;
      for (int k = 0; k < NRD; k++) begin
         ra = i_rd_addr[k*AW +: AW];
         rv = '0;
         if ((state == S_RUN) && (ra != '0)) begin
            rv = regs[ra];
            for (int j = 0; j < NWR; j++) begin
               if (i_wr_en[j] && (i_wr_addr[j*AW +: AW] == ra)) begin
                  rv = i_wr_data[j*XLEN +: XLEN];
               end
            end
         end
         o_rd_data[k*XLEN +: XLEN] = rv;
      end
   end

   for (genvar j = 0; j < NWR; j++) begin : g_wr_chk
      a_wr_addr_known: assert property (@(posedge i_clk) disable iff (!i_reset_n)
         i_wr_en[j] |-> !$isunknown(i_wr_addr[j*AW +: AW]));
   end

   a_ready_hold: assert property (@(posedge i_clk) $fell(o_ready) |-> !$past(i_reset_n));

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: init sweep, bypass, write conflicts, x0 handling, reset during INIT.
module tb_regfile_mp;

   localparam logic [31:0] SP_EXP = 32'h1234_5670;

   logic        clk;
   logic        reset_n;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic        ready;
   logic [4:0]  init_idx;

   int          n_vec = 0;
   int          n_mis = 0;
   logic [31:0] model [32];

   regfile_mp #(
      .XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .SP_IDX(2), .SP_RESET(SP_EXP)
   ) dut (
      .i_clk      (clk),
      .i_reset_n  (reset_n),
      .i_rd_addr  (rd_addr),
      .o_rd_data  (rd_data),
      .i_wr_en    (wr_en),
      .i_wr_addr  (wr_addr),
      .i_wr_data  (wr_data),
      .o_ready    (ready),
      .o_init_idx (init_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_init();
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      model[2] = SP_EXP;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic rd_all(input string tag);
      for (int r = 0; r < 32; r++) begin
         @(negedge clk);
         rd_addr = {5'(31 - r), 5'(r)};
         #1;
         chk(tag, rd_data[31:0], model[r]);
         chk(tag, rd_data[63:32], model[31 - r]);
      end
   endtask

   task automatic wait_ready(output int cyc);
      cyc = -1;
      for (int i = 1; i <= 40 && cyc < 0; i++) begin
         step();
         if (ready) cyc = i;
      end
   endtask

   initial begin
      int cyc;
      int found;
      reset_n = 1'b0;
      wr_en   = '0;
      wr_addr = '0;
      wr_data = '0;
      rd_addr = '0;
      model_init();

      // reset held 3 cycles
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", ready, 0);
      chk("rst_idx", init_idx, 1);

      // write attempts to x3 during INIT must be ignored, reads must be 0
      reset_n = 1'b1;
      wr_en   = 2'b01;
      wr_addr = {5'd0, 5'd3};
      wr_data = {32'h0, 32'h0000_00AB};
      rd_addr = {5'd2, 5'd3};
      step();
      chk("init_idx_step", init_idx, 2);
      chk("init_rd0", rd_data[31:0], 0);
      chk("init_rd1", rd_data[63:32], 0);
      repeat (5) step();
      chk("init_ready_low", ready, 0);
      wr_en = 2'b00;
      wait_ready(cyc);
      chk("init_len", 6 + cyc, 31);
      chk("run_idx", init_idx, 0);
      rd_all("init_vals");

      // bypass on write-read same cycle, then array read
      @(negedge clk);
      wr_en   = 2'b01;
      wr_addr = {5'd0, 5'd5};
      wr_data = {32'h0, 32'hDEAD_BEEF};
      rd_addr = {5'd5, 5'd5};
      #1;
      chk("bypass_rd0", rd_data[31:0], 32'hDEAD_BEEF);
      chk("bypass_rd1", rd_data[63:32], 32'hDEAD_BEEF);
      step();
      wr_en = 2'b00;
      #1;
      chk("array_rd0", rd_data[31:0], 32'hDEAD_BEEF);
      model[5] = 32'hDEAD_BEEF;

      // conflict: both ports write x7, port1 wins
      @(negedge clk);
      wr_en   = 2'b11;
      wr_addr = {5'd7, 5'd7};
      wr_data = {32'h22, 32'h11};
      rd_addr = {5'd7, 5'd7};
      #1;
      chk("conflict_byp0", rd_data[31:0], 32'h22);
      chk("conflict_byp1", rd_data[63:32], 32'h22);
      step();
      wr_en = 2'b00;
      #1;
      chk("conflict_array", rd_data[31:0], 32'h22);
      model[7] = 32'h22;

      // distinct addresses written together
      @(negedge clk);
      wr_en   = 2'b11;
      wr_addr = {5'd9, 5'd8};
      wr_data = {32'h99, 32'h88};
      rd_addr = {5'd9, 5'd8};
      #1;
      chk("dual_byp0", rd_data[31:0], 32'h88);
      chk("dual_byp1", rd_data[63:32], 32'h99);
      step();
      wr_en = 2'b00;
      model[8] = 32'h88;
      model[9] = 32'h99;

      // disabled port must not bypass; port0 write to x0 dropped
      @(negedge clk);
      wr_en   = 2'b01;
      wr_addr = {5'd11, 5'd0};
      wr_data = {32'h55, 32'h5};
      rd_addr = {5'd11, 5'd0};
      #1;
      chk("x0_port0_rd", rd_data[31:0], 0);
      chk("no_byp_disabled", rd_data[63:32], model[11]);
      step();
      wr_en = 2'b00;

      // x0 write on port1 dropped
      @(negedge clk);
      wr_en   = 2'b10;
      wr_addr = {5'd0, 5'd4};
      wr_data = {32'hFFFF_FFFF, 32'h0};
      rd_addr = {5'd0, 5'd0};
      #1;
      chk("x0_same_cycle0", rd_data[31:0], 0);
      chk("x0_same_cycle1", rd_data[63:32], 0);
      step();
      wr_en = 2'b00;
      rd_all("after_writes");

      // reset mid-RUN, then reset pulse at init_idx 10
      @(negedge clk);
      reset_n = 1'b0;
      step();
      chk("rerst_ready", ready, 0);
      chk("rerst_idx", init_idx, 1);
      reset_n = 1'b1;
      found = 0;
      for (int i = 0; i < 40 && found == 0; i++) begin
         step();
         if (init_idx == 5'd10) found = 1;
      end
      chk("reach_idx10", found, 1);
      reset_n = 1'b0;
      step();
      chk("restart_idx", init_idx, 1);
      chk("restart_ready", ready, 0);
      reset_n = 1'b1;
      wait_ready(cyc);
      chk("reinit_len", cyc, 31);
      model_init();
      rd_all("reinit_vals");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
